store_unit: RTL and testbench
=============================

# store_unit

Parametrised store unit for the RISC-V core's memory stage. It replaces fixed funct3-to-byte-enable decoding with full store handling: it decodes SB/SH/SW (and SD when XLEN=64), aligns data and byte enables to the address offset, and drives a req/ack data-memory write port. Misaligned stores that cross a word boundary are either split into two bus writes or rejected with an exception, selected by parameter. It sits between the execute/memory pipeline register and the data-memory interface.

## Interface
- XLEN, 32, data/bus width in bits; legal values 32 or 64; NB = XLEN/8 byte lanes, OFS_W = log2(NB)
- ADDR_W, 32, address width
- SPLIT_MISALIGNED, 1, 1 = split boundary-crossing stores into two writes; 0 = raise misaligned exception

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request from pipeline
- st_ready  out  1  unit can accept a request
- st_funct3  in  3  store type: 000 SB, 001 SH, 010 SW, 011 SD (XLEN=64 only)
- st_addr  in  ADDR_W  byte address
- st_data  in  XLEN  store data, right-justified
- st_done  out  1  one-cycle pulse: store completed on the bus
- st_exc  out  1  one-cycle pulse: store rejected, no bus access made
- st_exc_code  out  2  valid with st_exc: 01 misaligned, 10 illegal funct3
- mem_req  out  1  write request to data memory
- mem_addr  out  ADDR_W  word-aligned address (low OFS_W bits zero)
- mem_wdata  out  XLEN  lane-aligned write data
- mem_be  out  NB  byte enables
- mem_ack  in  1  memory accepted current write

## Operation
- FSM states: IDLE, REQ1, REQ2, RESP.
- IDLE: st_ready=1, mem_req=0. On st_valid: latch funct3/addr/data, go to RESP (exception) or REQ1.
- Size: SB=1, SH=2, SW=4, SD=8 bytes. funct3 100-111, or 011 with XLEN=32, is illegal -> RESP with st_exc, code 10.
- off = st_addr[OFS_W-1:0]. Wide mask (2*NB bits) = ((1<<size)-1) << off; wide data (2*XLEN) = st_data << (8*off); bytes above size in st_data are masked out.
- Crossing = off+size > NB. Crossing with SPLIT_MISALIGNED=0 -> RESP with st_exc, code 01, no mem_req. Misaligned but not crossing (e.g. SH at off 1) is legal and done in one write.
- REQ1: mem_req=1, mem_addr = addr with low OFS_W bits cleared, mem_be = wide mask[NB-1:0], mem_wdata = wide data[XLEN-1:0]. Held stable until mem_ack. On ack: crossing -> REQ2, else -> RESP with st_done.
- REQ2: mem_addr = REQ1 address + NB (wraps modulo 2^ADDR_W), mem_be = wide mask[2NB-1:NB], mem_wdata = wide data[2XLEN-1:XLEN]. On ack -> RESP with st_done.
- RESP: exactly one of st_done/st_exc high for one cycle, st_ready=0, then IDLE.
- Illegal funct3 takes priority over misalignment.
- mem_ack while mem_req=0 is ignored. mem_be and mem_wdata are 0 whenever mem_req=0.

## Timing
- Reset: state IDLE; st_ready=1 from first cycle after reset; mem_req, mem_addr, mem_wdata, mem_be, st_done, st_exc, st_exc_code all 0.
- All outputs registered, except st_ready (decoded from state).
- Accept at edge T -> mem_req high from T+1. Ack at cycle T+1 (zero wait) -> st_done at T+2, st_ready at T+3. Split store with zero-wait acks: st_done at T+3.
- Exception: accept at T -> st_exc at T+1, st_ready at T+2; mem_req never asserted.
- Each wait cycle (mem_req=1, mem_ack=0) adds one cycle; request fields remain unchanged.
- rst mid-operation: next edge returns to IDLE, mem_req drops; any in-flight write is abandoned with no st_done. A split store reset after its first ack leaves only the first half written.
- st_valid while st_ready=0 is ignored; pipeline holds the request.

## Test plan
- Reset: hold rst 2 cycles -> every output 0 except st_ready=1; mem_ack pulses ignored.
- SB addr 0x2003 data 0x12345677, zero-wait ack -> one write: mem_addr 0x2000, be 1000, wdata 0x77000000; st_done 2 cycles after accept.
- SW addr 0x1002 data 0xAABBCCDD, SPLIT=1 -> write 0x1000 be 1100 wdata 0xCCDD0000, then 0x1004 be 0011 wdata 0x0000AABB; single st_done after second ack.
- SH addr 0x3003 data 0x1234, SPLIT=0 -> st_exc with code 01 one cycle after accept, no mem_req; SH at 0x3001 -> one write be 0110 wdata 0x00123400.
- funct3 011 with XLEN=32 -> st_exc code 10. XLEN=64: SD addr 0x8 data 0x0102030405060708 -> be 0xFF, mem_addr 0x8.
- SW at 0x1002 with ack delayed 3 cycles, rst asserted during REQ2 -> outputs stable while waiting; after reset mem_req=0, no st_done, IDLE.

Source files
------------

// File: rtl/store_unit_if.sv
// Store request and data-memory write port between pipeline, store unit and memory.
interface store_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              st_valid;
  logic              st_ready;
  logic [2:0]        st_funct3;
  logic [ADDR_W-1:0] st_addr;
  logic [XLEN-1:0]   st_data;
  logic              st_done;
  logic              st_exc;
  logic [1:0]        st_exc_code;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NB-1:0]     mem_be;
  logic              mem_ack;

  modport master (
    output st_valid, st_funct3, st_addr, st_data, mem_ack,
    input  st_ready, st_done, st_exc, st_exc_code,
    input  mem_req, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, mem_ack,
    output st_ready, st_done, st_exc, st_exc_code,
    output mem_req, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_unit.sv
// Store unit: decodes SB/SH/SW/SD, lane-aligns data/enables, splits or rejects word-crossing stores.
// Accept -> mem_req next cycle, st_done one cycle after the final ack; st_ready low while busy, request fields held until ack.
module store_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  store_unit_if.slave  bus
);
  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ1, REQ2, RESP} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic              st_done_q, st_done_d;
  logic              st_exc_q, st_exc_d;
  logic [1:0]        st_exc_code_q, st_exc_code_d;
  logic              cross_q, cross_d;
  logic [NB-1:0]     be_hi_q, be_hi_d;
  logic [XLEN-1:0]   wdata_hi_q, wdata_hi_d;

  logic [3:0]        size;
  logic              illegal;
  logic [OFS_W-1:0]  off;
  logic              crossing;
  logic [NB-1:0]     lane_m;
  logic [XLEN-1:0]   data_m;
  logic [2*NB-1:0]   mask_w;
  logic [2*XLEN-1:0] data_w;

  always_comb begin
    size    = 4'd0;
    illegal = 1'b0;
    case (bus.st_funct3)
      3'b000:  size = 4'd1;
      3'b001:  size = 4'd2;
      3'b010:  size = 4'd4;
      3'b011: begin
        if (XLEN == 64) size = 4'd8;
        else            illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign off      = bus.st_addr[OFS_W-1:0];
  assign crossing = (5'(off) + 5'(size)) > 5'(NB);

  // Keep only the low 'size' bytes, then shift both halves of the double-width window by the offset.
  always_comb begin
    lane_m = '0;
    data_m = '0;
    for (int k = 0; k < NB; k++) begin
      if (4'(k) < size) begin
        lane_m[k]         = 1'b1;
        data_m[8*k +: 8]  = bus.st_data[8*k +: 8];
      end
    end
    mask_w = {{NB{1'b0}}, lane_m} << off;
    data_w = {{XLEN{1'b0}}, data_m} << {off, 3'b000};
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    mem_be_d      = '0;
    st_done_d     = 1'b0;
    st_exc_d      = 1'b0;
    st_exc_code_d = 2'b00;
    cross_d       = cross_q;
    be_hi_d       = be_hi_q;
    wdata_hi_d    = wdata_hi_q;

    case (state_q)
      IDLE: begin
        if (bus.st_valid) begin
          if (illegal) begin
            state_d       = RESP;
            st_exc_d      = 1'b1;
            st_exc_code_d = 2'b10;
          end else if (crossing && !SPLIT_MISALIGNED) begin
            state_d       = RESP;
            st_exc_d      = 1'b1;
            st_exc_code_d = 2'b01;
          end else begin
            state_d     = REQ1;
            mem_req_d   = 1'b1;
            mem_addr_d  = {bus.st_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            mem_be_d    = mask_w[NB-1:0];
            mem_wdata_d = data_w[XLEN-1:0];
            cross_d     = crossing;
            be_hi_d     = mask_w[2*NB-1:NB];
            wdata_hi_d  = data_w[2*XLEN-1:XLEN];
          end
        end
      end
      REQ1, REQ2: begin
        if (!bus.mem_ack) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_be_d    = mem_be_q;
          mem_wdata_d = mem_wdata_q;
        end else if (state_q == REQ1 && cross_q) begin
          state_d     = REQ2;
          mem_req_d   = 1'b1;
          mem_addr_d  = mem_addr_q + ADDR_W'(NB);
          mem_be_d    = be_hi_q;
          mem_wdata_d = wdata_hi_q;
        end else begin
          state_d   = RESP;
          st_done_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      st_done_q     <= 1'b0;
      st_exc_q      <= 1'b0;
      st_exc_code_q <= 2'b00;
      cross_q       <= 1'b0;
      be_hi_q       <= '0;
      wdata_hi_q    <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      st_done_q     <= st_done_d;
      st_exc_q      <= st_exc_d;
      st_exc_code_q <= st_exc_code_d;
      cross_q       <= cross_d;
      be_hi_q       <= be_hi_d;
      wdata_hi_q    <= wdata_hi_d;
    end
  end

  assign bus.st_ready    = (state_q == IDLE);
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.st_done     = st_done_q;
  assign bus.st_exc      = st_exc_q;
  assign bus.st_exc_code = st_exc_code_q;
endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: transaction model checks the split-mode 32-bit unit every cycle; directed checks cover reject mode and XLEN=64.
module tb_store_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  store_unit_if #(.XLEN(32), .ADDR_W(32)) a_if ();
  store_unit_if #(.XLEN(32), .ADDR_W(32)) b_if ();
  store_unit_if #(.XLEN(64), .ADDR_W(32)) c_if ();

  store_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  store_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
  store_unit #(.XLEN(64), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(c_if));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction model for dut_a: the list of bus writes a store must produce, or the exception it must raise.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  bit         pend    = 1'b0;
  bit         exp_exc = 1'b0;
  logic [1:0] exp_code = 2'b00;

  function automatic void model_accept(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    int          size;
    int          off;
    logic [63:0] keep;
    logic [63:0] wide;
    logic [7:0]  m;
    wr_t         w;
    size = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : (f3 == 3'b010) ? 4 : 0;
    pend    = 1'b1;
    exp_exc = 1'b0;
    exp_q.delete();
    if (size == 0) begin
      exp_exc  = 1'b1;
      exp_code = 2'b10;
      return;
    end
    off  = int'(addr % 4);
    keep = (64'd1 << (8 * size)) - 64'd1;
    wide = ({32'd0, data} & keep) << (8 * off);
    m    = 8'(((1 << size) - 1) << off);
    w.addr = addr & 32'hFFFF_FFFC;
    w.be   = m[3:0];
    w.data = wide[31:0];
    exp_q.push_back(w);
    if (off + size > 4) begin
      w.addr = (addr & 32'hFFFF_FFFC) + 32'd4;
      w.be   = m[7:4];
      w.data = wide[63:32];
      exp_q.push_back(w);
    end
  endfunction

  always @(negedge clk) begin
    bit resp_now;
    if (rst) begin
      pend    = 1'b0;
      exp_exc = 1'b0;
      exp_q.delete();
    end else begin
      resp_now = pend && (exp_exc || exp_q.size() == 0);
      chk("a_ready", a_if.st_ready, !pend);
      chk("a_req",   a_if.mem_req, pend && !exp_exc && exp_q.size() != 0);
      chk("a_done",  a_if.st_done, pend && !exp_exc && exp_q.size() == 0);
      chk("a_exc",   a_if.st_exc,  pend && exp_exc);
      if (pend && exp_exc) chk("a_code", a_if.st_exc_code, exp_code);
      if (!a_if.mem_req) begin
        chk("a_be_idle",    a_if.mem_be,    0);
        chk("a_wdata_idle", a_if.mem_wdata, 0);
      end else if (exp_q.size() != 0) begin
        chk("a_addr",  a_if.mem_addr,  exp_q[0].addr);
        chk("a_be",    a_if.mem_be,    exp_q[0].be);
        chk("a_wdata", a_if.mem_wdata, exp_q[0].data);
        if (a_if.mem_ack) void'(exp_q.pop_front());
      end
      if (resp_now) pend = 1'b0;
      if (a_if.st_valid && a_if.st_ready)
        model_accept(a_if.st_funct3, a_if.st_addr, a_if.st_data);
    end
  end

  int          done_c, exc_c, ready_c, cap_n;
  logic [1:0]  cap_code;
  logic [31:0] cap_addr[2];
  logic [3:0]  cap_be[2];
  logic [31:0] cap_data[2];

  // Issue one store to dut_a, ack each write after ack_wait wait cycles, record cycle numbers relative to accept.
  task automatic run_a(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data, input int ack_wait);
    int w;
    w = 0;
    done_c = -1; exc_c = -1; ready_c = -1; cap_n = 0; cap_code = 2'b00;
    a_if.st_valid  = 1'b1;
    a_if.st_funct3 = f3;
    a_if.st_addr   = addr;
    a_if.st_data   = data;
    step();
    a_if.st_valid = 1'b0;
    for (int c = 1; c <= 40 && ready_c < 0; c++) begin
      if (a_if.st_done && done_c < 0) done_c = c;
      if (a_if.st_exc && exc_c < 0) begin
        exc_c    = c;
        cap_code = a_if.st_exc_code;
      end
      if (a_if.st_ready) ready_c = c;
      a_if.mem_ack = 1'b0;
      if (a_if.mem_req && ready_c < 0) begin
        if (w == ack_wait) begin
          a_if.mem_ack = 1'b1;
          w = 0;
          if (cap_n < 2) begin
            cap_addr[cap_n] = a_if.mem_addr;
            cap_be[cap_n]   = a_if.mem_be;
            cap_data[cap_n] = a_if.mem_wdata;
          end
          cap_n++;
        end else begin
          w++;
        end
      end
      if (ready_c < 0) step();
    end
    a_if.mem_ack = 1'b0;
    if (ready_c < 0) chk("a_timeout_ready", a_if.st_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    a_if.st_valid = 0; a_if.st_funct3 = 0; a_if.st_addr = 0; a_if.st_data = 0; a_if.mem_ack = 0;
    b_if.st_valid = 0; b_if.st_funct3 = 0; b_if.st_addr = 0; b_if.st_data = 0; b_if.mem_ack = 0;
    c_if.st_valid = 0; c_if.st_funct3 = 0; c_if.st_addr = 0; c_if.st_data = 0; c_if.mem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_ready",  a_if.st_ready,    1);
    chk("rst_req",    a_if.mem_req,     0);
    chk("rst_addr",   a_if.mem_addr,    0);
    chk("rst_wdata",  a_if.mem_wdata,   0);
    chk("rst_be",     a_if.mem_be,      0);
    chk("rst_done",   a_if.st_done,     0);
    chk("rst_exc",    a_if.st_exc,      0);
    chk("rst_code",   a_if.st_exc_code, 0);
    chk("rst_c_ready", c_if.st_ready,   1);

    // Stray acks while idle must not start anything.
    a_if.mem_ack = 1'b1;
    repeat (3) step();
    a_if.mem_ack = 1'b0;
    chk("stray_ack_req",  a_if.mem_req, 0);
    chk("stray_ack_done", a_if.st_done, 0);
    chk("stray_ack_rdy",  a_if.st_ready, 1);

    run_a(3'b000, 32'h2003, 32'h1234_5677, 0);
    chk("sb_done_c", done_c, 2);
    chk("sb_ready_c", ready_c, 3);
    chk("sb_nwr", cap_n, 1);
    chk("sb_addr", cap_addr[0], 32'h2000);
    chk("sb_be", cap_be[0], 4'b1000);
    chk("sb_wdata", cap_data[0], 32'h7700_0000);

    run_a(3'b010, 32'h1002, 32'hAABB_CCDD, 0);
    chk("swx_done_c", done_c, 3);
    chk("swx_nwr", cap_n, 2);
    chk("swx_addr0", cap_addr[0], 32'h1000);
    chk("swx_be0", cap_be[0], 4'b1100);
    chk("swx_wdata0", cap_data[0], 32'hCCDD_0000);
    chk("swx_addr1", cap_addr[1], 32'h1004);
    chk("swx_be1", cap_be[1], 4'b0011);
    chk("swx_wdata1", cap_data[1], 32'h0000_AABB);

    run_a(3'b001, 32'h3001, 32'h0000_1234, 0);
    chk("sh1_nwr", cap_n, 1);
    chk("sh1_addr", cap_addr[0], 32'h3000);
    chk("sh1_be", cap_be[0], 4'b0110);
    chk("sh1_wdata", cap_data[0], 32'h0012_3400);

    run_a(3'b011, 32'h0000_0010, 32'h5555_5555, 0);
    chk("sd32_exc_c", exc_c, 1);
    chk("sd32_code", cap_code, 2'b10);
    chk("sd32_ready_c", ready_c, 2);
    chk("sd32_nwr", cap_n, 0);
    chk("sd32_done_c", done_c, -1);

    run_a(3'b111, 32'h0000_0003, 32'h0, 0);
    chk("f7_code", cap_code, 2'b10);

    run_a(3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 2);
    chk("swwait_done_c", done_c, 4);
    chk("swwait_wdata", cap_data[0], 32'hDEAD_BEEF);
    chk("swwait_be", cap_be[0], 4'hF);

    run_a(3'b001, 32'h1003, 32'hFFFF_1234, 1);
    chk("shx_done_c", done_c, 5);
    chk("shx_wdata0", cap_data[0], 32'h3400_0000);
    chk("shx_be0", cap_be[0], 4'b1000);
    chk("shx_wdata1", cap_data[1], 32'h0000_0012);
    chk("shx_be1", cap_be[1], 4'b0001);

    run_a(3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 0);
    chk("wrap_addr0", cap_addr[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", cap_addr[1], 32'h0000_0000);
    chk("wrap_wdata1", cap_data[1], 32'h0000_1122);

    // Split store with slow acks, reset while the second half waits.
    a_if.st_valid = 1'b1; a_if.st_funct3 = 3'b010; a_if.st_addr = 32'h1002; a_if.st_data = 32'hAABB_CCDD;
    step();
    a_if.st_valid = 1'b0;
    repeat (3) begin
      chk("rw_hold_addr", a_if.mem_addr, 32'h1000);
      chk("rw_hold_be", a_if.mem_be, 4'b1100);
      step();
    end
    a_if.mem_ack = 1'b1;
    step();
    a_if.mem_ack = 1'b0;
    chk("rw_req2_addr", a_if.mem_addr, 32'h1004);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw_req", a_if.mem_req, 0);
    chk("rw_ready", a_if.st_ready, 1);
    chk("rw_be", a_if.mem_be, 0);
    repeat (4) begin
      chk("rw_no_done", a_if.st_done, 0);
      step();
    end

    // Reject mode: crossing store raises misaligned, non-crossing one proceeds.
    b_if.st_valid = 1'b1; b_if.st_funct3 = 3'b001; b_if.st_addr = 32'h3003; b_if.st_data = 32'h0000_1234;
    step();
    b_if.st_valid = 1'b0;
    chk("b_exc", b_if.st_exc, 1);
    chk("b_code", b_if.st_exc_code, 2'b01);
    chk("b_noreq", b_if.mem_req, 0);
    chk("b_busy", b_if.st_ready, 0);
    step();
    chk("b_exc_pulse", b_if.st_exc, 0);
    chk("b_ready", b_if.st_ready, 1);
    chk("b_noreq2", b_if.mem_req, 0);

    b_if.st_valid = 1'b1; b_if.st_funct3 = 3'b101; b_if.st_addr = 32'h3003;
    step();
    b_if.st_valid = 1'b0;
    chk("b_illegal_code", b_if.st_exc_code, 2'b10);
    step();

    b_if.st_valid = 1'b1; b_if.st_funct3 = 3'b001; b_if.st_addr = 32'h3001; b_if.st_data = 32'h0000_1234;
    step();
    b_if.st_valid = 1'b0;
    chk("b_sh_req", b_if.mem_req, 1);
    chk("b_sh_addr", b_if.mem_addr, 32'h3000);
    chk("b_sh_be", b_if.mem_be, 4'b0110);
    chk("b_sh_wdata", b_if.mem_wdata, 32'h0012_3400);
    b_if.mem_ack = 1'b1;
    step();
    b_if.mem_ack = 1'b0;
    chk("b_sh_done", b_if.st_done, 1);
    chk("b_sh_req_off", b_if.mem_req, 0);
    step();

    // 64-bit doubleword store.
    c_if.st_valid = 1'b1; c_if.st_funct3 = 3'b011; c_if.st_addr = 32'h8; c_if.st_data = 64'h0102_0304_0506_0708;
    step();
    c_if.st_valid = 1'b0;
    chk("c_sd_req", c_if.mem_req, 1);
    chk("c_sd_addr", c_if.mem_addr, 32'h8);
    chk("c_sd_be", c_if.mem_be, 8'hFF);
    chk("c_sd_wdata", c_if.mem_wdata, 64'h0102_0304_0506_0708);
    c_if.mem_ack = 1'b1;
    step();
    c_if.mem_ack = 1'b0;
    chk("c_sd_done", c_if.st_done, 1);
    step();
    chk("c_sd_ready", c_if.st_ready, 1);

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
